// File: rtl/fifo_stream_arbiter.sv
// Packet-granular round-robin arbiter merging N_PORTS write/send streams into one
// registered output stream, with an idle-timeout release and sticky timeout flag.
module fifo_stream_arbiter #(
    parameter int N_PORTS = 5,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [N_PORTS*DATA_W-1:0] in_data,
    input  logic [N_PORTS-1:0]        in_write,
    input  logic [N_PORTS-1:0]        in_send,
    output logic [N_PORTS-1:0]        in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_write,
    output logic                      out_send,
    input  logic                      out_full,
    output logic [N_PORTS-1:0]        grant,
    output logic [31:0]               pkt_count,
    output logic                      err_timeout
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_reg, state_next;
    logic [N_PORTS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   last_reg, last_next;
    logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [DATA_W-1:0]  out_data_reg, out_data_next;
    logic               out_write_reg, out_write_next;
    logic               out_send_reg, out_send_next;
    logic [31:0]        pkt_count_reg, pkt_count_next;
    logic               err_reg, err_next;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               sel_write;
    logic               sel_send;
    logic [DATA_W-1:0]  sel_data;
    logic               accept;

    // Data view padded to a power of two so any owner index selects a defined word
    logic [DATA_W-1:0] port_data [2**IDX_W];

    generate
        for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_port_data
            if (gi < N_PORTS) begin : g_real
                assign port_data[gi] = in_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign port_data[gi] = '0;
            end
        end
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ready
            assign in_ready[gi] = grant_reg[gi] & ~out_full;
        end
    endgenerate

    assign sel_write = |(in_write & grant_reg);
    assign sel_send  = |(in_send & grant_reg);
    assign sel_data  = port_data[owner_reg];
    assign accept    = (state_reg == GRANT) && sel_write && !out_full;

    // Round-robin pick: first requester scanning upward from last+1
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = IDX_W'((int'(last_reg) + k) % N_PORTS);
            if (!pick_found && in_write[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        idle_cnt_next  = idle_cnt_reg;
        out_data_next  = out_data_reg;
        out_write_next = 1'b0;
        out_send_next  = 1'b0;
        pkt_count_next = pkt_count_reg;
        err_next       = err_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = GRANT;
                    grant_next    = N_PORTS'(1) << pick_idx;
                    owner_next    = pick_idx;
                    idle_cnt_next = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    out_data_next  = sel_data;
                    out_write_next = 1'b1;
                    out_send_next  = sel_send;
                    idle_cnt_next  = '0;
                    if (sel_send) begin
                        pkt_count_next = pkt_count_reg + 32'd1;
                        last_next      = owner_reg;
                        grant_next     = '0;
                        state_next     = IDLE;
                    end
                end else if (idle_cnt_reg == CNT_MAX) begin
                    // Stalled owner: drop it without emitting anything
                    err_next   = 1'b1;
                    last_next  = owner_reg;
                    grant_next = '0;
                    state_next = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            owner_reg     <= '0;
            last_reg      <= LAST_RST;
            idle_cnt_reg  <= '0;
            out_data_reg  <= '0;
            out_write_reg <= 1'b0;
            out_send_reg  <= 1'b0;
            pkt_count_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            idle_cnt_reg  <= idle_cnt_next;
            out_data_reg  <= out_data_next;
            out_write_reg <= out_write_next;
            out_send_reg  <= out_send_next;
            pkt_count_reg <= pkt_count_next;
            err_reg       <= err_next;
        end
    end

    assign grant       = grant_reg;
    assign out_data    = out_data_reg;
    assign out_write   = out_write_reg;
    assign out_send    = out_send_reg;
    assign pkt_count   = pkt_count_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Randomised bench for fifo_stream_arbiter: per-port packet sources and a
// rule-level model of grant order, beat forwarding, packet count and timeout.
module tb_fifo_stream_arbiter;

    localparam int N  = 5;
    localparam int DW = 256;
    localparam int TO = 8;
    localparam int MAXB = 32;

    logic            clk_clk = 1'b0;
    logic            reset_reset;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_write;
    logic [N-1:0]    in_send;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_write;
    logic            out_send;
    logic            out_full;
    logic [N-1:0]    grant;
    logic [31:0]     pkt_count;
    logic            err_timeout;

    fifo_stream_arbiter #(.N_PORTS(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .in_data(in_data), .in_write(in_write), .in_send(in_send), .in_ready(in_ready),
        .out_data(out_data), .out_write(out_write), .out_send(out_send), .out_full(out_full),
        .grant(grant), .pkt_count(pkt_count), .err_timeout(err_timeout)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;

    // Sources
    logic [DW-1:0] src_data [N][MAXB];
    bit            src_send [N][MAXB];
    int            src_len [N];
    int            src_pos [N];
    bit            presented [N];
    bit            block [N];
    int            gap_pct = 0;
    logic [N-1:0]  last_ready;

    // Reference model
    int          m_owner;
    int          m_last;
    int          m_wait;
    int unsigned m_pkts;
    bit          m_err;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic load_packet(input int p, input int len, input bit with_send);
        for (int i = 0; i < len; i++) begin
            src_data[p][src_len[p]] = rand_word();
            src_send[p][src_len[p]] = with_send && (i == len - 1);
            src_len[p]++;
        end
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        in_write = '0; in_send = '0; in_data = '0; out_full = 1'b0;
        for (int p = 0; p < N; p++) begin
            src_len[p] = 0; src_pos[p] = 0; presented[p] = 1'b0; block[p] = 1'b0;
        end
        m_owner = -1; m_last = N - 1; m_wait = 0; m_pkts = 0; m_err = 1'b0;
        gap_pct = 0;
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
    endtask

    // One clock: drive sources, check handshake, step model, check outputs.
    task automatic cycle(input bit full_v);
        logic [N-1:0]  req, exp_ready, exp_grant;
        logic [DW-1:0] acc_data;
        bit            acc_send;
        int            acc, c;
        acc_data = '0; acc_send = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (!presented[p] && src_pos[p] < src_len[p] && !block[p]
                && $urandom_range(99) >= gap_pct)
                presented[p] = 1'b1;
            in_write[p] = presented[p];
            if (presented[p]) begin
                in_data[p*DW +: DW] = src_data[p][src_pos[p]];
                in_send[p] = src_send[p][src_pos[p]];
            end else begin
                in_data[p*DW +: DW] = rand_word();
                in_send[p] = 1'($urandom_range(1));
            end
        end
        out_full = full_v;
        #1;
        exp_ready = (m_owner >= 0 && !full_v) ? (N'(1) << m_owner) : '0;
        last_ready = in_ready;
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
        end
        req = in_write;
        acc = -1;
        if (m_owner >= 0 && !full_v && ((req >> m_owner) & N'(1)) != '0) acc = m_owner;
        if (acc >= 0) begin
            acc_data = src_data[acc][src_pos[acc]];
            acc_send = src_send[acc][src_pos[acc]];
        end
        @(posedge clk_clk);
        #1;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_owner < 0 && ((req >> c) & N'(1)) != '0) m_owner = c;
            end
            m_wait = 0;
        end else if (acc >= 0) begin
            src_pos[acc]++;
            presented[acc] = 1'b0;
            m_wait = 0;
            if (acc_send) begin
                m_pkts++;
                m_last = m_owner;
                m_owner = -1;
            end
        end else if (m_wait == TO - 1) begin
            m_err = 1'b1;
            m_last = m_owner;
            m_owner = -1;
        end else begin
            m_wait++;
        end
        exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        checks++;
        if (grant !== exp_grant) begin
            errors++;
            $display("FAIL grant: got %b expected %b", grant, exp_grant);
        end
        checks++;
        if (out_write !== (acc >= 0)) begin
            errors++;
            $display("FAIL out_write: got %b expected %b", out_write, acc >= 0);
        end
        if (acc >= 0) begin
            checks++;
            if (out_data !== acc_data || out_send !== acc_send) begin
                errors++;
                $display("FAIL beat port%0d: got data %h send %b expected data %h send %b",
                         acc, out_data[63:0], out_send, acc_data[63:0], acc_send);
            end
        end
        checks++;
        if (pkt_count !== m_pkts || err_timeout !== m_err) begin
            errors++;
            $display("FAIL status: got pkt %0d err %b expected pkt %0d err %b",
                     pkt_count, err_timeout, m_pkts, m_err);
        end
    endtask

    function automatic bit all_done();
        bit d = (m_owner < 0);
        for (int p = 0; p < N; p++) if (src_pos[p] < src_len[p]) d = 1'b0;
        return d;
    endfunction

    task automatic run_until_idle(input int max_cycles, input bit rand_full);
        int n = 0;
        int full_run = 0;
        bit f;
        while (!all_done() && n < max_cycles) begin
            f = rand_full && (full_run < 2) && ($urandom_range(99) < 20);
            full_run = f ? full_run + 1 : 0;
            cycle(f);
            n++;
        end
        checks++;
        if (!all_done()) begin
            errors++;
            $display("FAIL drain: sources still busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        in_write = '0; in_send = '0; in_data = '0; out_full = 1'b0;
        #3;
        checks++;
        if (grant !== '0 || in_ready !== '0 || out_write !== 1'b0 || out_send !== 1'b0
            || out_data !== '0 || pkt_count !== 32'd0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got grant %b ready %b wr %b send %b pkt %0d err %b expected all zero",
                     grant, in_ready, out_write, out_send, pkt_count, err_timeout);
        end
        do_reset();
        cycle(1'b0);
        checks++;
        if (grant !== '0) begin
            errors++;
            $display("FAIL idle_no_req: got grant %b expected 0", grant);
        end
    endtask

    task automatic test_single_port();
        logic [5:0] ow, os;
        do_reset();
        load_packet(2, 4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0);
            if (i == 0) begin
                checks++;
                if (grant !== 5'b00100) begin
                    errors++;
                    $display("FAIL single_grant: got %b expected 00100", grant);
                end
            end
            ow[i] = out_write;
            os[i] = out_send;
        end
        checks++;
        if (ow !== 6'b011110 || os !== 6'b010000) begin
            errors++;
            $display("FAIL single_pattern: got write %b send %b expected 011110 010000", ow, os);
        end
        checks++;
        if (pkt_count !== 32'd1) begin
            errors++;
            $display("FAIL single_pkt: got %0d expected 1", pkt_count);
        end
    endtask

    task automatic test_fairness();
        int order [$];
        int when [$];
        logic [N-1:0] prev;
        int exp_port;
        do_reset();
        for (int p = 0; p < N; p++) begin
            load_packet(p, 2, 1'b1);
            load_packet(p, 2, 1'b1);
        end
        prev = '0;
        for (int i = 0; i < 40 && !all_done(); i++) begin
            cycle(1'b0);
            if (prev == '0 && grant != '0) begin
                for (int p = 0; p < N; p++) if (grant[p]) order.push_back(p);
                when.push_back(i);
            end
            prev = grant;
        end
        checks++;
        if (order.size() != 10) begin
            errors++;
            $display("FAIL fair_count: got %0d grants expected 10", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            exp_port = k % N;
            checks++;
            if (order[k] != exp_port) begin
                errors++;
                $display("FAIL fair_order[%0d]: got port %0d expected %0d", k, order[k], exp_port);
            end
            if (k > 0) begin
                checks++;
                if (when[k] - when[k-1] != 3) begin
                    errors++;
                    $display("FAIL fair_gap[%0d]: got %0d cycles expected 3", k, when[k] - when[k-1]);
                end
            end
        end
        checks++;
        if (pkt_count !== 32'd10) begin
            errors++;
            $display("FAIL fair_pkt: got %0d expected 10", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        int stall = 0;
        do_reset();
        load_packet(1, 6, 1'b1);
        for (int i = 0; i < 30 && !all_done(); i++) begin
            if (src_pos[1] == 2 && stall < 3) begin
                cycle(1'b1);
                stall++;
                checks++;
                if (last_ready[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready: got %b expected 0 while full", last_ready[1]);
                end
            end else begin
                cycle(1'b0);
            end
            if (out_write) beats++;
        end
        checks++;
        if (beats != 6 || pkt_count !== 32'd1 || stall != 3) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats pkt %0d stalls %0d expected 6 1 3",
                     beats, pkt_count, stall);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load_packet(3, 1, 1'b0);
        load_packet(4, 1, 1'b1);
        for (int i = 1; i <= 11; i++) begin
            cycle(1'b0);
            if (i == 9) begin
                checks++;
                if (grant !== 5'b01000 || err_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL to_hold: got grant %b err %b expected 01000 0", grant, err_timeout);
                end
            end
            if (i == 10) begin
                checks++;
                if (grant !== '0 || err_timeout !== 1'b1 || pkt_count !== 32'd0
                    || out_write !== 1'b0) begin
                    errors++;
                    $display("FAIL to_release: got grant %b err %b pkt %0d wr %b expected 0 1 0 0",
                             grant, err_timeout, pkt_count, out_write);
                end
            end
            if (i == 11) begin
                checks++;
                if (grant !== 5'b10000) begin
                    errors++;
                    $display("FAIL to_next: got grant %b expected 10000", grant);
                end
            end
        end
        run_until_idle(50, 1'b0);
    endtask

    task automatic test_boundary();
        do_reset();
        load_packet(0, 2, 1'b1);
        cycle(1'b0);
        cycle(1'b0);
        block[0] = 1'b1;
        repeat (TO - 1) cycle(1'b0);
        block[0] = 1'b0;
        cycle(1'b0);
        checks++;
        if (err_timeout !== 1'b0 || pkt_count !== 32'd1 || out_send !== 1'b1 || grant !== '0) begin
            errors++;
            $display("FAIL boundary: got err %b pkt %0d send %b grant %b expected 0 1 1 0",
                     err_timeout, pkt_count, out_send, grant);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        load_packet(1, 2, 1'b1);
        run_until_idle(20, 1'b0);
        load_packet(0, 4, 1'b1);
        while (!(m_owner == 0 && src_pos[0] == 2) && n < 20) begin
            cycle(1'b0);
            n++;
            if (m_owner == 0 && src_len[2] == 0) load_packet(2, 2, 1'b1);
        end
        checks++;
        if (out_write !== 1'b1) begin
            errors++;
            $display("FAIL rm_setup: got out_write %b expected 1 before reset", out_write);
        end
        reset_reset = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || in_ready !== '0 || out_write !== 1'b0 || out_send !== 1'b0
            || out_data !== '0 || pkt_count !== 32'd0) begin
            errors++;
            $display("FAIL rm_clear: got grant %b ready %b wr %b pkt %0d expected all zero",
                     grant, in_ready, out_write, pkt_count);
        end
        m_owner = -1; m_last = N - 1; m_wait = 0; m_pkts = 0; m_err = 1'b0;
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        cycle(1'b0);
        checks++;
        if (grant !== 5'b00001) begin
            errors++;
            $display("FAIL rm_regrant: got %b expected 00001", grant);
        end
        run_until_idle(50, 1'b0);
    endtask

    task automatic test_random();
        int total_pkts;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            gap_pct = 20;
            total_pkts = 0;
            for (int p = 0; p < N; p++) begin
                int np = $urandom_range(3, 1);
                for (int k = 0; k < np; k++) begin
                    load_packet(p, $urandom_range(4, 1), 1'b1);
                    total_pkts++;
                end
            end
            run_until_idle(3000, 1'b1);
            checks++;
            if (pkt_count !== 32'(total_pkts)) begin
                errors++;
                $display("FAIL rand_pkts round %0d: got %0d expected %0d", round, pkt_count, total_pkts);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
